rx_byte_assembler: RTL and testbench
====================================

# rx_byte_assembler

Receive-side byte assembler sitting directly downstream of the bit unstuffer in the USB 2.0 receive path. Consumes the unstuffed serial bit stream (LSB first), hunts for the SYNC pattern, then packs bits into bytes and reports the PID and packet boundaries. Its byte outputs feed the packet decoder; packet status (PID, alignment, optional CRC16) is reported at EOP.

## Interface
- BYTE_CNT_W, 11, width of the per-packet byte counter (PID byte included); saturates at all-ones
- gclk  in  1  system clock, all state on rising edge
- reset_l  in  1  asynchronous, active-low reset
- cs3_l  in  1  synchronous active-low clear; same effect as reset, one cycle
- rx_din  in  1  serial bit from unstuffer (unstuff_dout)
- halt_rx_shift  in  1  1 = stuffed bit this cycle; rx_din ignored
- rx_eop  in  1  one-cycle EOP strobe
- rx_byte  out  8  last assembled byte
- rx_byte_valid  out  1  one-cycle strobe, rx_byte new
- rx_pid  out  4  PID[3:0] of current packet
- rx_pid_valid  out  1  one-cycle strobe on PID byte capture
- pid_error  out  1  PID check-nibble mismatch; held until next SYNC
- rx_byte_count  out  BYTE_CNT_W  bytes in current packet
- packet_done  out  1  one-cycle strobe after EOP
- align_error  out  1  valid with packet_done: EOP with partial byte
- crc16_ok  out  1  valid with packet_done (see Configuration)

## Operation
- Bit accepted in a cycle iff halt_rx_shift=0 and rx_eop=0.
- States: HUNT, PID, DATA.
- HUNT: accepted bits shift into 8-bit window at MSB (shift right). Window == 8'h80 -> PID; clear bit_cnt, byte count, pid_error. rx_eop in HUNT ignored (no packet_done).
- PID: 8 accepted bits -> rx_byte, rx_byte_valid=1, rx_pid=byte[3:0], rx_pid_valid=1, pid_error = (byte[7:4] != ~byte[3:0]), count=1 -> DATA.
- DATA: every 8 accepted bits -> rx_byte, rx_byte_valid, count+1 (saturating).
- rx_eop in PID or DATA: packet_done=1 next cycle, align_error = (bit_cnt != 0), -> HUNT, window cleared. rx_eop wins over a simultaneous bit (bit dropped).
- rx_byte, rx_pid, rx_byte_count, pid_error hold until next SYNC match.
- cs3_l=0 or reset: all state and outputs to 0, state HUNT; mid-packet data discarded, no packet_done.

## Timing
- Reset values: all outputs 0, state HUNT, window 8'h00.
- rx_byte_valid/rx_pid_valid: asserted the cycle after the edge sampling the 8th accepted bit; exactly one cycle.
- packet_done, align_error, crc16_ok: registered on the edge sampling rx_eop; packet_done high one cycle; align_error/crc16_ok held until next SYNC.
- halt_rx_shift cycles freeze bit_cnt, window, CRC; any number of consecutive halts allowed.
- SYNC match and first PID bit may be on consecutive cycles.

## Configuration
- RX_CRC16_CHECK_EN defined: serial CRC16 (x^16+x^15+x^2+1, init 16'hFFFF) over every accepted bit in DATA; at EOP crc16_ok = (register == residual 16'h800D, x^15..x^0). Reset with SYNC match.
- Not defined: no CRC logic; crc16_ok constant 0.

## Structure
- Package rx_pkg: state enum (HUNT, PID, DATA), SYNC_BYTE=8'h80, CRC16_POLY, CRC16_INIT, CRC16_RESIDUAL.
- Sub-module rx_crc16_serial (enable, clear, bit in, 16-bit reg out), instantiated only under RX_CRC16_CHECK_EN.

## Test plan
- SYNC 0,0,0,0,0,0,0,1 then PID bits of 8'hE1 LSB first -> rx_pid_valid one cycle, rx_pid=4'h1, pid_error=0, rx_byte=8'hE1, count=1.
- PID byte 8'hE2 -> pid_error=1, bytes still delivered.
- SYNC, PID 8'hC3, data 8'hA5 with halt_rx_shift=1 inserted after 6th data bit -> rx_byte=8'hA5, count=2, halted bit ignored.
- SYNC, PID, 3 data bits, rx_eop -> packet_done one cycle, align_error=1; rx_eop during HUNT -> no packet_done.
- With RX_CRC16_CHECK_EN: DATA0 payload 8'h00,8'h01 + correct CRC16 bytes -> crc16_ok=1; flip one payload bit -> crc16_ok=0.
- cs3_l=0 mid-DATA -> outputs 0, state HUNT, no packet_done; later SYNC reassembles normally.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the USB receive byte assembler.
package rx_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    PID  = 2'd1,
    DATA = 2'd2
  } rx_state_e;

  localparam logic [7:0]  SYNC_BYTE      = 8'h80;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // A PID byte carries its own complement in the upper nibble.
  function automatic logic pid_check_bad(input logic [7:0] pid_byte);
    return pid_byte[7:4] != ~pid_byte[3:0];
  endfunction

endpackage

// File: rtl/rx_byte_assembler_if.sv
// Bit-stream input and byte/packet status output bundle of the assembler.
// master = unstuffer / packet-decoder side, slave = the assembler itself.
interface rx_byte_assembler_if #(
  parameter int BYTE_CNT_W = 11
);

  logic                  rx_din;
  logic                  halt_rx_shift;
  logic                  rx_eop;
  logic [7:0]            rx_byte;
  logic                  rx_byte_valid;
  logic [3:0]            rx_pid;
  logic                  rx_pid_valid;
  logic                  pid_error;
  logic [BYTE_CNT_W-1:0] rx_byte_count;
  logic                  packet_done;
  logic                  align_error;
  logic                  crc16_ok;

  modport master (
    output rx_din, halt_rx_shift, rx_eop,
    input  rx_byte, rx_byte_valid, rx_pid, rx_pid_valid, pid_error,
           rx_byte_count, packet_done, align_error, crc16_ok
  );

  modport slave (
    input  rx_din, halt_rx_shift, rx_eop,
    output rx_byte, rx_byte_valid, rx_pid, rx_pid_valid, pid_error,
           rx_byte_count, packet_done, align_error, crc16_ok
  );

endinterface

// File: rtl/rx_crc16_serial.sv
// Bit-serial USB CRC16 (x^16+x^15+x^2+1), register bit 15 = x^15.
// Input bits arrive LSB first per byte, exactly as they come off the wire.
module rx_crc16_serial
  import rx_pkg::*;
(
  input  logic        gclk,
  input  logic        reset_l,
  input  logic        enable,
  input  logic        clear,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic feedback;

  assign feedback = bit_in ^ crc[15];

  // Galois LFSR step per accepted bit; clear reloads the seed.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/rx_byte_assembler.sv
// USB receive byte assembler: hunts for SYNC in the unstuffed bit stream,
// packs LSB-first bits into bytes, captures the PID and reports packet
// status at EOP. Optional CRC16 residual check when RX_CRC16_CHECK_EN is
// defined; otherwise crc16_ok is tied low.
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter int BYTE_CNT_W = 11
) (
  input  logic                gclk,
  input  logic                reset_l,
  input  logic                cs3_l,
  rx_byte_assembler_if.slave  rx
);

  rx_state_e             state;
  rx_state_e             state_next;
  logic [7:0]            window;
  logic [7:0]            window_shift;
  logic [2:0]            bit_cnt;
  logic                  accept;
  logic                  sync_hit;
  logic                  byte_done;
  logic                  eop_hit;

  logic [7:0]            byte_q;
  logic                  byte_valid_q;
  logic [3:0]            pid_q;
  logic                  pid_valid_q;
  logic                  pid_error_q;
  logic [BYTE_CNT_W-1:0] byte_count_q;
  logic                  packet_done_q;
  logic                  align_error_q;

  // EOP takes priority: a bit presented alongside it is dropped.
  assign accept       = !rx.halt_rx_shift && !rx.rx_eop;
  assign window_shift = {rx.rx_din, window[7:1]};
  assign sync_hit     = (state == HUNT) && accept && (window_shift == SYNC_BYTE);
  assign byte_done    = (state != HUNT) && accept && (bit_cnt == 3'd7);
  assign eop_hit      = (state != HUNT) && rx.rx_eop;

  // State register; the synchronous clear forces HUNT.
  always_ff @(posedge gclk or negedge reset_l) begin
    // NOTE: registers use <= so every flop samples the pre-edge values.
    if (!reset_l) begin
      state <= HUNT;
    end else if (!cs3_l) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_next (no latch).
    state_next = state;
    unique case (state)
      HUNT: if (sync_hit) state_next = PID;
      PID: begin
        if (eop_hit)        state_next = HUNT;
        else if (byte_done) state_next = DATA;
      end
      DATA: if (eop_hit) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // Shift window, bit counter, byte/PID capture and packet status.
  always_ff @(posedge gclk or negedge reset_l) begin
    // NOTE: cs3_l clears the same flops as reset, but synchronously.
    if (!reset_l || !cs3_l) begin
      window        <= 8'h00;
      bit_cnt       <= 3'd0;
      byte_q        <= 8'h00;
      byte_valid_q  <= 1'b0;
      pid_q         <= 4'h0;
      pid_valid_q   <= 1'b0;
      pid_error_q   <= 1'b0;
      byte_count_q  <= '0;
      packet_done_q <= 1'b0;
      align_error_q <= 1'b0;
    end else begin
      byte_valid_q  <= 1'b0;
      pid_valid_q   <= 1'b0;
      packet_done_q <= 1'b0;
      if (eop_hit) begin
        packet_done_q <= 1'b1;
        align_error_q <= (bit_cnt != 3'd0);
        window        <= 8'h00;
        bit_cnt       <= 3'd0;
      end else if (accept) begin
        window <= window_shift;
        if (sync_hit) begin
          bit_cnt       <= 3'd0;
          byte_count_q  <= '0;
          pid_error_q   <= 1'b0;
          align_error_q <= 1'b0;
        end else if (state != HUNT) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            byte_q       <= window_shift;
            byte_valid_q <= 1'b1;
            if (state == PID) begin
              pid_q        <= window_shift[3:0];
              pid_valid_q  <= 1'b1;
              pid_error_q  <= pid_check_bad(window_shift);
              byte_count_q <= BYTE_CNT_W'(1);
            end else if (byte_count_q != '1) begin
              byte_count_q <= byte_count_q + BYTE_CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign rx.rx_byte       = byte_q;
  assign rx.rx_byte_valid = byte_valid_q;
  assign rx.rx_pid        = pid_q;
  assign rx.rx_pid_valid  = pid_valid_q;
  assign rx.pid_error     = pid_error_q;
  assign rx.rx_byte_count = byte_count_q;
  assign rx.packet_done   = packet_done_q;
  assign rx.align_error   = align_error_q;

`ifdef RX_CRC16_CHECK_EN
  logic [15:0] crc;
  logic        crc16_ok_q;

  rx_crc16_serial u_crc (
    .gclk    (gclk),
    .reset_l (reset_l),
    .enable  ((state == DATA) && accept),
    .clear   (sync_hit || !cs3_l),
    .bit_in  (rx.rx_din),
    .crc     (crc)
  );

  // Residual comparison latched at EOP, cleared by the next SYNC.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l || !cs3_l) begin
      crc16_ok_q <= 1'b0;
    end else if (sync_hit) begin
      crc16_ok_q <= 1'b0;
    end else if (eop_hit) begin
      crc16_ok_q <= (crc == CRC16_RESIDUAL);
    end
  end

  assign rx.crc16_ok = crc16_ok_q;
`else
  assign rx.crc16_ok = 1'b0;
`endif

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Self-checking bench for rx_byte_assembler: reset state, a table of
// packets, hand-written halt / alignment / clear / CRC sequences, random
// packets against a packet-level model, and byte-count saturation.
module tb_rx_byte_assembler;

  localparam int BYTE_CNT_W = 11;
  localparam int MAX_COUNT  = (1 << BYTE_CNT_W) - 1;
`ifdef RX_CRC16_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic gclk = 1'b0;
  logic reset_l;
  logic cs3_l;

  rx_byte_assembler_if #(.BYTE_CNT_W(BYTE_CNT_W)) rx_if ();

  rx_byte_assembler #(.BYTE_CNT_W(BYTE_CNT_W)) dut (
    .gclk    (gclk),
    .reset_l (reset_l),
    .cs3_l   (cs3_l),
    .rx      (rx_if)
  );

  always #5 gclk = ~gclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_data[$];
  logic [3:0] exp_pid;
  int         n_valid;
  int         pid_seen;
  int         done_seen;

  typedef struct {
    logic [7:0] pid;
    logic [7:0] d0, d1, d2;
    int         n_data;
    int         partial;
    logic       e_pid_err;
    logic       e_align;
    int         e_count;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: drive inputs, wait for the edge, then sample 1 time unit later.
  task automatic cycle(input logic din, input logic halt, input logic eop);
    rx_if.rx_din        = din;
    rx_if.halt_rx_shift = halt;
    rx_if.rx_eop        = eop;
    @(posedge gclk);
    #1;
    if (rx_if.rx_byte_valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("unexpected_byte", 32'(rx_if.rx_byte), 32'hFFFF_FFFF);
      else                   check("rx_byte", 32'(rx_if.rx_byte), 32'(exp_q.pop_front()));
    end
    if (rx_if.rx_pid_valid) begin
      pid_seen++;
      check("rx_pid", 32'(rx_if.rx_pid), 32'(exp_pid));
    end
    if (rx_if.packet_done) done_seen++;
  endtask

  // Accepted bit, optionally preceded by up to three halted cycles carrying junk.
  task automatic send_bit(input logic b, input int halt_pct);
    for (int h = 0; h < 3; h++) begin
      if ($urandom_range(99) < halt_pct) cycle(1'($urandom), 1'b1, 1'b0);
    end
    cycle(b, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int halt_pct);
    for (int i = 0; i < 8; i++) send_bit(b[i], halt_pct);
  endtask

  task automatic start_packet(input logic [7:0] pid);
    exp_q.delete();
    exp_q.push_back(pid);
    exp_pid   = pid[3:0];
    n_valid   = 0;
    pid_seen  = 0;
    done_seen = 0;
  endtask

  // EOP (with a random bit that must be dropped) and end-of-packet checks.
  task automatic finish_packet(input logic e_pid_err, input logic e_align, input int e_count,
                               input logic e_crc, input bit chk_crc, input int e_bytes);
    cycle(1'($urandom), 1'b0, 1'b1);
    check("packet_done", 32'(rx_if.packet_done), 32'd1);
    check("align_error", 32'(rx_if.align_error), 32'(e_align));
    check("rx_byte_count", 32'(rx_if.rx_byte_count), 32'(e_count));
    check("pid_error", 32'(rx_if.pid_error), 32'(e_pid_err));
    if (chk_crc) check("crc16_ok", 32'(rx_if.crc16_ok), 32'(e_crc));
    cycle(1'b0, 1'b0, 1'b0);
    check("packet_done_one_cycle", 32'(rx_if.packet_done), 32'd0);
    check("bytes_delivered", 32'(n_valid), 32'(e_bytes));
    check("pid_strobes", 32'(pid_seen), 32'd1);
    check("done_strobes", 32'(done_seen), 32'd1);
    check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_packet(input logic [7:0] pid, input int partial, input int halt_pct,
                            input logic e_pid_err, input logic e_align, input int e_count,
                            input logic e_crc, input bit chk_crc);
    start_packet(pid);
    foreach (tx_data[i]) exp_q.push_back(tx_data[i]);
    send_byte(8'h80, halt_pct);
    send_byte(pid, halt_pct);
    foreach (tx_data[i]) send_byte(tx_data[i], halt_pct);
    for (int i = 0; i < partial; i++) send_bit(1'($urandom), halt_pct);
    finish_packet(e_pid_err, e_align, e_count, e_crc, chk_crc, tx_data.size() + 1);
  endtask

  // Reference USB CRC16 in reflected byte-wise form over tx_data[0..n-1];
  // the low result byte goes on the wire first.
  function automatic logic [15:0] usb_crc16(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, tx_data[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_byte"}, 32'(rx_if.rx_byte), 32'd0);
    check({tag, "_rx_byte_valid"}, 32'(rx_if.rx_byte_valid), 32'd0);
    check({tag, "_rx_pid"}, 32'(rx_if.rx_pid), 32'd0);
    check({tag, "_rx_pid_valid"}, 32'(rx_if.rx_pid_valid), 32'd0);
    check({tag, "_pid_error"}, 32'(rx_if.pid_error), 32'd0);
    check({tag, "_rx_byte_count"}, 32'(rx_if.rx_byte_count), 32'd0);
    check({tag, "_packet_done"}, 32'(rx_if.packet_done), 32'd0);
    check({tag, "_align_error"}, 32'(rx_if.align_error), 32'd0);
    check({tag, "_crc16_ok"}, 32'(rx_if.crc16_ok), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hE1, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1};
    vecs[1] = '{8'hE2, 8'h5A, 8'h00, 8'h00, 1, 0, 1'b1, 1'b0, 2};
    vecs[2] = '{8'h4B, 8'h00, 8'h00, 8'h00, 0, 3, 1'b0, 1'b1, 1};
    vecs[3] = '{8'h69, 8'h11, 8'h22, 8'h33, 3, 0, 1'b0, 1'b0, 4};
    vecs[4] = '{8'hD2, 8'hAA, 8'h55, 8'h00, 2, 5, 1'b0, 1'b1, 3};
    vecs[5] = '{8'h0F, 8'hFF, 8'h00, 8'h00, 1, 7, 1'b0, 1'b1, 2};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1'b1, 1'b1, 1};

    rx_if.rx_din        = 1'b0;
    rx_if.halt_rx_shift = 1'b0;
    rx_if.rx_eop        = 1'b0;
    cs3_l   = 1'b1;
    reset_l = 1'b0;
    n_valid = 0; pid_seen = 0; done_seen = 0; exp_pid = 4'h0;
    repeat (3) @(posedge gclk);
    #1 reset_l = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    check_all_zero("reset");

    // Table of packets.
    for (int v = 0; v < 7; v++) begin
      tx_data.delete();
      if (vecs[v].n_data > 0) tx_data.push_back(vecs[v].d0);
      if (vecs[v].n_data > 1) tx_data.push_back(vecs[v].d1);
      if (vecs[v].n_data > 2) tx_data.push_back(vecs[v].d2);
      run_packet(vecs[v].pid, vecs[v].partial, 0, vecs[v].e_pid_err, vecs[v].e_align,
                 vecs[v].e_count, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
    end

    // Halt after the 6th data bit, carrying the opposite bit value.
    begin
      logic [7:0] b;
      b = 8'hA5;
      start_packet(8'hC3);
      exp_q.push_back(b);
      send_byte(8'h80, 0);
      send_byte(8'hC3, 0);
      for (int i = 0; i < 8; i++) begin
        if (i == 6) cycle(~b[6], 1'b1, 1'b0);
        cycle(b[i], 1'b0, 1'b0);
      end
      finish_packet(1'b0, 1'b0, 2, 1'b0, 1'b0, 2);
      check("halt_rx_byte", 32'(rx_if.rx_byte), 32'hA5);
    end

    // Partial byte, then EOP while hunting: no packet_done, status held.
    tx_data.delete();
    run_packet(8'h96, 3, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    done_seen = 0;
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("hunt_eop_no_done", 32'(done_seen), 32'd0);
    check("hunt_eop_align_held", 32'(rx_if.align_error), 32'd1);
    check("hunt_eop_count_held", 32'(rx_if.rx_byte_count), 32'd1);

    // DATA0 payload 00,01 with its CRC, then one flipped payload bit.
    begin
      logic [15:0] c;
      tx_data.delete();
      tx_data.push_back(8'h00);
      tx_data.push_back(8'h01);
      c = usb_crc16(2);
      tx_data.push_back(c[7:0]);
      tx_data.push_back(c[15:8]);
      run_packet(8'hC3, 0, 0, 1'b0, 1'b0, 5, CRC_EN, 1'b1);
      tx_data[0] = tx_data[0] ^ 8'h01;
      run_packet(8'hC3, 0, 0, 1'b0, 1'b0, 5, 1'b0, 1'b1);
    end

    // Synchronous clear in the middle of DATA.
    start_packet(8'hB5);
    exp_q.push_back(8'h3C);
    send_byte(8'h80, 0);
    send_byte(8'hB5, 0);
    send_byte(8'h3C, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    cs3_l = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    cs3_l = 1'b1;
    check_all_zero("clear");
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("clear_no_done", 32'(done_seen), 32'd0);
    tx_data.delete();
    tx_data.push_back(8'h77);
    run_packet(8'hE1, 0, 0, 1'b0, 1'b0, 2, 1'b0, 1'b0);

    // Random packets against the packet-level model.
    for (int p = 0; p < 30; p++) begin
      logic [7:0] pid;
      logic [3:0] nib;
      logic [15:0] c;
      int n, partial;
      logic good;
      nib = 4'($urandom);
      pid = $urandom_range(1) ? {~nib, nib} : 8'($urandom);
      n = $urandom_range(5);
      partial = $urandom_range(1) ? 0 : $urandom_range(7, 1);
      tx_data.delete();
      for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom));
      if (n >= 2 && $urandom_range(1) == 1) begin
        c = usb_crc16(n - 2);
        tx_data[n-2] = c[7:0];
        tx_data[n-1] = c[15:8];
      end
      good = 1'b0;
      if (n >= 2) begin
        c = usb_crc16(n - 2);
        good = (tx_data[n-2] == c[7:0]) && (tx_data[n-1] == c[15:8]);
      end
      run_packet(pid, partial, 25, pid[7:4] != ~pid[3:0], partial != 0,
                 (n + 1 > MAX_COUNT) ? MAX_COUNT : n + 1,
                 CRC_EN & good, (partial == 0) && (n >= 2));
      repeat ($urandom_range(3)) cycle(1'b0, 1'b0, 1'b0);
    end

    // Byte counter saturates at all-ones.
    tx_data.delete();
    for (int i = 0; i < MAX_COUNT + 3; i++) tx_data.push_back(8'($urandom));
    run_packet(8'h4B, 0, 0, 1'b0, 1'b0, MAX_COUNT, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
